fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter IBUF_DEPTH, default 4, meaning: instruction-buffer entries; power of two, >= 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2, meaning: max accepted-but-unanswered SRAM reads; 1..IBUF_DEPTH.
REQ-003 Parameter RESET_PC, default 32'h1c000000, meaning: fetch PC after reset.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 inst_sram_en  out  1  read request valid.
REQ-007 inst_sram_wr  out  1  constant 0.
REQ-008 inst_sram_we  out  4  constant 0.
REQ-009 inst_sram_size  out  2  constant 2'b10.
REQ-010 inst_sram_addr  out  32  current fetch PC (fpc).
REQ-011 inst_sram_wdata  out  32  constant 0.
REQ-012 inst_sram_rdata  in  32  read data, valid with data_ok.
REQ-013 inst_sram_addr_ok  in  1  request accepted when high with inst_sram_en.
REQ-014 inst_sram_data_ok  in  1  one in-order response returned.
REQ-015 ex_valid / ex_entry  in  1 / 32  exception redirect and target.
REQ-016 ertn_valid / ertn_entry  in  1 / 32  ertn redirect and target.
REQ-017 br_taken / br_target  in  1 / 32  branch redirect and target.
REQ-018 br_stall  in  1  suppress new requests.
REQ-019 fs2ds_valid  out  1  head entry valid to ID.
REQ-020 fs2ds_pc / fs2ds_inst / fs2ds_adef  out  32 / 32 / 1  head entry PC, instruction, fetch-address-error flag.
REQ-021 ds_allowin  in  1  ID accepts head when high with fs2ds_valid.

Function
REQ-022 Redirect = ex_valid | ertn_valid | br_taken; target priority ex_entry > ertn_entry > br_target.
REQ-023 Redirect cycle: fpc <= target; IBUF emptied; inst_sram_en = 0; fs2ds_valid = 0; halt flag cleared.
REQ-024 Redirect cycle: cancel_cnt <= cancel_cnt + live_cnt - (live data_ok this cycle ? 1 : 0); live_cnt <= 0; a data_ok in the redirect cycle is dropped.
REQ-025 inst_sram_en = ~redirect & ~br_stall & ~halt & fpc[1:0]==0 & (live_cnt + cancel_cnt) < MAX_OUTSTANDING & (ibuf_cnt + live_cnt) < IBUF_DEPTH (IBUF slot reserved per live request).
REQ-026 Accept (en & addr_ok): fpc <= fpc + 4 (mod 2^32); fpc pushed to pending-PC FIFO (depth MAX_OUTSTANDING); live_cnt +1.
REQ-027 addr_ok while en = 0: ignored, no state change.
REQ-028 data_ok with cancel_cnt > 0: cancel_cnt -1, pending-PC FIFO popped, rdata discarded; cancelled responses always precede live ones.
REQ-029 data_ok with cancel_cnt == 0 and no redirect: push {popped pending PC, rdata, adef=0} into IBUF; live_cnt -1.
REQ-030 data_ok with live_cnt == cancel_cnt == 0: ignored; bench flags protocol error.
REQ-031 fpc[1:0] != 0, no redirect, live_cnt == 0, ibuf_cnt < IBUF_DEPTH: push {fpc, 32'b0, adef=1} without SRAM request; set halt (no fetch until next redirect).
REQ-032 fs2ds_valid = ~ibuf_empty & ~redirect; fields from IBUF head (zeros when empty); head popped when fs2ds_valid & ds_allowin.
REQ-033 Same-cycle push and pop: ibuf_cnt unchanged; push into full IBUF is impossible by REQ-025/031 reservation.
REQ-034 Counters $clog2(MAX+1) bits, IBUF pointers $clog2(IBUF_DEPTH) bits, wrapping naturally.
REQ-035 Same-cycle accept and data_ok: live_cnt net unchanged.
REQ-036 First response latency: rdata in IBUF, visible on fs2ds 1 cycle after data_ok.

Reset
REQ-037 While resetn = 0: fpc = RESET_PC; live_cnt, cancel_cnt, ibuf_cnt, pointers, halt = 0; inst_sram_en = 0; fs2ds_valid = 0.
REQ-038 Reset mid-operation discards all outstanding state; responses arriving after release with zero counters are ignored (REQ-030).
REQ-039 First cycle after release: inst_sram_en = 1 with addr = RESET_PC unless br_stall/redirect.

Verification
REQ-040 Reset release, addr_ok and data_ok tied high, ds_allowin = 1 -> fs2ds_pc 1c000000, 1c000004, 1c000008 on consecutive cycles, adef 0.
REQ-041 ds_allowin = 0, SRAM always ready, defaults -> exactly 4 entries buffered, inst_sram_en drops, no data lost; ds_allowin = 1 -> 4 entries drained in order.
REQ-042 Two requests accepted, br_taken with br_target 1c000100 before responses -> cancel_cnt = 2, both responses dropped, next fs2ds_pc = 1c000100.
REQ-043 ex_valid (ex_entry 1c008000) and br_taken same cycle with one data_ok -> fpc = 1c008000, that response dropped, IBUF empty next cycle.
REQ-044 Redirect to 1c000102 -> no SRAM request, one entry pc 1c000102, adef 1, inst 0; fetch halted until next redirect.
REQ-045 br_stall held 3 cycles with IBUF draining -> inst_sram_en 0 for 3 cycles, buffered entries still delivered, fetch resumes at the unchanged fpc.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order SRAM reads from the fetch PC,
// tracks outstanding responses (live vs. cancelled by a redirect), buffers
// returned instructions with their PCs in a small FIFO and hands the head
// entry to the decode stage. A misaligned fetch PC produces a single
// address-error entry and halts fetching until the next redirect.
module fetch_queue #(
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_en,
    output logic        inst_sram_wr,
    output logic [3:0]  inst_sram_we,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic        ex_valid,
    input  logic [31:0] ex_entry,
    input  logic        ertn_valid,
    input  logic [31:0] ertn_entry,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_stall,
    output logic        fs2ds_valid,
    output logic [31:0] fs2ds_pc,
    output logic [31:0] fs2ds_inst,
    output logic        fs2ds_adef,
    input  logic        ds_allowin
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(IBUF_DEPTH);
    localparam int NW = $clog2(IBUF_DEPTH + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   r_fpc;
    logic [CW-1:0] r_live_cnt;
    logic [CW-1:0] r_cancel_cnt;
    logic          r_halt;
    logic [NW-1:0] r_ibuf_cnt;
    logic [IW-1:0] r_ibuf_rd;
    logic [IW-1:0] r_ibuf_wr;
    logic [PW-1:0] r_pend_rd;
    logic [PW-1:0] r_pend_wr;
    logic [31:0]   r_ibuf_pc   [IBUF_DEPTH];
    logic [31:0]   r_ibuf_inst [IBUF_DEPTH];
    logic          r_ibuf_adef [IBUF_DEPTH];
    logic [31:0]   r_pend_pc   [MAX_OUTSTANDING];

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_slot_ok;
    logic          w_room_ok;
    logic          w_en;
    logic          w_accept;
    logic          w_dok_valid;
    logic          w_dok_cancel;
    logic          w_dok_live;
    logic          w_push_data;
    logic          w_push_adef;
    logic          w_push;
    logic          w_pop;
    logic          w_ibuf_nonempty;
    logic [31:0]   w_push_pc;

    // Pending-PC FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_redirect = ex_valid | ertn_valid | br_taken;
    assign w_target   = ex_valid ? ex_entry : (ertn_valid ? ertn_entry : br_target);

    // Each live request already owns an IBUF slot, so data_ok can never overflow it.
    assign w_slot_ok = (32'(r_live_cnt) + 32'(r_cancel_cnt)) < 32'(MAX_OUTSTANDING);
    assign w_room_ok = (32'(r_ibuf_cnt) + 32'(r_live_cnt)) < 32'(IBUF_DEPTH);

    // Gated by resetn so no request escapes while reset is asserted.
    assign w_en = resetn & ~w_redirect & ~br_stall & ~r_halt & (r_fpc[1:0] == 2'b00)
                & w_slot_ok & w_room_ok;
    assign w_accept = w_en & inst_sram_addr_ok;

    // Responses return in order: cancelled ones drain before any live one.
    assign w_dok_valid  = inst_sram_data_ok & ((r_live_cnt != '0) | (r_cancel_cnt != '0));
    assign w_dok_cancel = inst_sram_data_ok & (r_cancel_cnt != '0);
    assign w_dok_live   = inst_sram_data_ok & (r_cancel_cnt == '0) & (r_live_cnt != '0);

    assign w_ibuf_nonempty = (r_ibuf_cnt != '0);
    assign w_push_data = w_dok_live & ~w_redirect;
    assign w_push_adef = (r_fpc[1:0] != 2'b00) & ~w_redirect & ~r_halt
                       & (r_live_cnt == '0) & (r_ibuf_cnt != NW'(IBUF_DEPTH));
    assign w_push      = w_push_data | w_push_adef;
    assign w_push_pc   = w_push_data ? r_pend_pc[r_pend_rd] : r_fpc;

    assign fs2ds_valid = w_ibuf_nonempty & ~w_redirect;
    assign w_pop       = fs2ds_valid & ds_allowin;
    assign fs2ds_pc    = w_ibuf_nonempty ? r_ibuf_pc[r_ibuf_rd]   : 32'h0;
    assign fs2ds_inst  = w_ibuf_nonempty ? r_ibuf_inst[r_ibuf_rd] : 32'h0;
    assign fs2ds_adef  = w_ibuf_nonempty & r_ibuf_adef[r_ibuf_rd];

    assign inst_sram_en    = w_en;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = r_fpc;
    assign inst_sram_wdata = 32'h0;

    // Fetch PC, outstanding-request bookkeeping and halt flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fpc        <= RESET_PC;
            r_live_cnt   <= '0;
            r_cancel_cnt <= '0;
            r_halt       <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_wr    <= '0;
        end else begin
            if (w_accept)    r_pend_wr <= pend_next(r_pend_wr);
            if (w_dok_valid) r_pend_rd <= pend_next(r_pend_rd);
            if (w_redirect) begin
                r_fpc        <= w_target;
                r_halt       <= 1'b0;
                r_live_cnt   <= '0;
                r_cancel_cnt <= r_cancel_cnt + r_live_cnt - CW'(w_dok_valid);
            end else begin
                if (w_accept)    r_fpc  <= r_fpc + 32'd4;
                if (w_push_adef) r_halt <= 1'b1;
                case ({w_accept, w_dok_live})
                    2'b10:   r_live_cnt <= r_live_cnt + 1'b1;
                    2'b01:   r_live_cnt <= r_live_cnt - 1'b1;
                    default: r_live_cnt <= r_live_cnt;
                endcase
                if (w_dok_cancel) r_cancel_cnt <= r_cancel_cnt - 1'b1;
            end
        end
    end

    // Instruction buffer pointers and occupancy; a redirect flushes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ibuf_cnt <= '0;
            r_ibuf_rd  <= '0;
            r_ibuf_wr  <= '0;
        end else if (w_redirect) begin
            r_ibuf_cnt <= '0;
            r_ibuf_rd  <= '0;
            r_ibuf_wr  <= '0;
        end else begin
            if (w_push) r_ibuf_wr <= r_ibuf_wr + 1'b1;
            if (w_pop)  r_ibuf_rd <= r_ibuf_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_ibuf_cnt <= r_ibuf_cnt + 1'b1;
                2'b01:   r_ibuf_cnt <= r_ibuf_cnt - 1'b1;
                default: r_ibuf_cnt <= r_ibuf_cnt;
            endcase
        end
    end

    // Storage arrays; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (w_accept) r_pend_pc[r_pend_wr] <= r_fpc;
        if (w_push) begin
            r_ibuf_pc[r_ibuf_wr]   <= w_push_pc;
            r_ibuf_inst[r_ibuf_wr] <= w_push_data ? inst_sram_rdata : 32'h0;
            r_ibuf_adef[r_ibuf_wr] <= ~w_push_data;
        end
    end

endmodule
